// File: rtl/rca_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rca_io_pkg
// Brief    : Shared types and helpers for the RCA grid I/O channel array.
// Revision : 1.0 - initial release
// ============================================================================
package rca_io_pkg;

    // Per-channel I/O mode; RSVD is decoded as passthrough.
    typedef enum logic [1:0] {
        PASS = 2'd0,
        FIFO = 2'd1,
        REG  = 2'd2,
        RSVD = 2'd3
    } io_mode_t;

    // Width needed to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_io_channel.sv
`default_nettype none
// ============================================================================
// Module   : rca_io_channel
// Brief    : One grid I/O channel: output FIFO, LS request counter, one-cycle
//            register stage, sticky error flags and the mode output mux.
// Revision : 1.0 - initial release
// ============================================================================
module rca_io_channel
    import rca_io_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    input  logic              flush,
    input  logic              fifo_pop,
    input  logic              new_ls_request,
    input  logic              ls_request_ack,
    input  logic              stall,
    input  logic              err_clr,
    output logic              data_valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_full,
    output logic              ls_requested,
    output logic              overflow,
    output logic              underflow
);

    localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_ls_cnt;
    logic               r_reg_valid;
    logic [DATA_W-1:0]  r_reg_data;
    logic               r_overflow;
    logic               r_underflow;

    io_mode_t           w_mode;
    logic               w_is_fifo;
    logic               w_is_reg;
    logic               w_full;
    logic               w_not_empty;
    logic               w_push_try;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_evt;
    logic               w_udf_evt;
    logic               w_ack_udf;
    logic [CNT_W-1:0]   w_ls_next;

    assign w_mode      = io_mode_t'(mode);
    assign w_is_fifo   = (w_mode == FIFO);
    assign w_is_reg    = (w_mode == REG);
    assign w_full      = (r_count == c_DEPTH);
    assign w_not_empty = (r_count != '0);

    // A pop on a full FIFO frees the slot, so a same-cycle push is accepted.
    assign w_push_try = data_valid_in && w_is_fifo && !stall;
    assign w_push     = w_push_try && (!w_full || fifo_pop);
    assign w_pop      = fifo_pop && w_not_empty;
    assign w_ovf_evt  = w_push_try && w_full && !fifo_pop;
    assign w_udf_evt  = (fifo_pop && !w_not_empty) || w_ack_udf;

    // LS counter next value: saturates at depth, holds at zero, frozen on stall.
    always_comb begin
        w_ls_next = r_ls_cnt;
        w_ack_udf = 1'b0;
        if (!stall) begin
            if (new_ls_request && !ls_request_ack) begin
                if (r_ls_cnt != c_DEPTH) begin
                    w_ls_next = r_ls_cnt + CNT_W'(1);
                end
            end else if (ls_request_ack && !new_ls_request) begin
                if (r_ls_cnt == '0) begin
                    w_ack_udf = 1'b1;
                end else begin
                    w_ls_next = r_ls_cnt - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; stale entries are harmless because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, LS counter and REG valid; flush overrides traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ls_cnt    <= '0;
            r_reg_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_ls_cnt    <= w_ls_next;
            r_reg_valid <= w_is_reg && data_valid_in && !stall;
        end
    end

    // REG stage data holds its last capture until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_data <= '0;
        end else if (w_is_reg && data_valid_in && !stall) begin
            r_reg_data <= data_in;
        end
    end

    // Sticky error flags; a same-cycle event beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_evt) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Output mux follows the current mode; PASS/RSVD is purely combinational.
    always_comb begin
        data_valid_out = data_valid_in;
        data_out       = data_in;
        if (w_is_fifo) begin
            data_valid_out = w_not_empty;
            data_out       = r_mem[r_rd_ptr];
        end else if (w_is_reg) begin
            data_valid_out = r_reg_valid;
            data_out       = r_reg_data;
        end
    end

    assign fifo_count   = r_count;
    assign fifo_full    = w_full;
    assign ls_requested = (r_ls_cnt != '0);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: rtl/rca_io_channel_array.sv
`default_nettype none
// ============================================================================
// Module   : rca_io_channel_array
// Brief    : NUM_CH independent grid I/O channels; only stall, err_clr, clk
//            and rst are shared between channels.
// Revision : 1.0 - initial release
// ============================================================================
module rca_io_channel_array
    import rca_io_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        data_valid_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH*2-1:0]      mode,
    input  logic [NUM_CH-1:0]        flush,
    input  logic [NUM_CH-1:0]        fifo_pop,
    input  logic [NUM_CH-1:0]        new_ls_request,
    input  logic [NUM_CH-1:0]        ls_request_ack,
    input  logic                     stall,
    input  logic                     err_clr,
    output logic [NUM_CH-1:0]        data_valid_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH*CNT_W-1:0]  fifo_count,
    output logic [NUM_CH-1:0]        fifo_full,
    output logic [NUM_CH-1:0]        ls_requested,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        underflow
);

    // One channel instance per grid I/O lane, sliced out of the flat buses.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        rca_io_channel #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .data_valid_in  (data_valid_in[gi]),
            .data_in        (data_in[gi*DATA_W +: DATA_W]),
            .mode           (mode[gi*2 +: 2]),
            .flush          (flush[gi]),
            .fifo_pop       (fifo_pop[gi]),
            .new_ls_request (new_ls_request[gi]),
            .ls_request_ack (ls_request_ack[gi]),
            .stall          (stall),
            .err_clr        (err_clr),
            .data_valid_out (data_valid_out[gi]),
            .data_out       (data_out[gi*DATA_W +: DATA_W]),
            .fifo_count     (fifo_count[gi*CNT_W +: CNT_W]),
            .fifo_full      (fifo_full[gi]),
            .ls_requested   (ls_requested[gi]),
            .overflow       (overflow[gi]),
            .underflow      (underflow[gi])
        );
    end

endmodule
`default_nettype wire
